// File: rtl/pc_gen_unit.sv
// Program-counter generator: sequential/branch/jalr/mret next-PC selection
// with fetch-alignment checking, trap redirection and nested-trap tracking.
module pc_gen_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = 'h0000_0100,
  parameter int unsigned      ALIGN        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [1:0]      pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  input  logic [XLEN-1:0] jalrTarget,
  input  logic            trapReq,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic [XLEN-1:0] epc,
  output logic [1:0]      trapCause,
  output logic            trapTaken,
  output logic            inTrap,
  output logic            doubleTrap
);

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_EXT      = 2'b10
  } cause_e;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_BRANCH = 2'b01,
    SRC_JALR   = 2'b10,
    SRC_MRET   = 2'b11
  } src_e;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  cause_e          r_cause;
  logic            r_trap_taken;
  logic            r_in_trap;
  logic            r_double_trap;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_jalr_aligned;
  logic [XLEN-1:0] w_cand;
  logic            w_seq_like;
  logic            w_mis_bits;
  logic            w_misaligned;
  logic            w_do_mret;
  logic            w_trap;

  assign w_pc_plus4     = r_pc + XLEN'(4);
  assign w_jalr_aligned = jalrTarget & ~XLEN'(1);

  // mret outside a handler is treated exactly like sequential fetch,
  // so it must never be flagged as misaligned.
  assign w_do_mret  = (src_e'(pcSrc) == SRC_MRET) && r_in_trap;
  assign w_seq_like = (src_e'(pcSrc) == SRC_SEQ) ||
                      ((src_e'(pcSrc) == SRC_MRET) && !r_in_trap);

  always_comb begin
    w_cand = w_pc_plus4;
    case (src_e'(pcSrc))
      SRC_SEQ:    w_cand = w_pc_plus4;
      SRC_BRANCH: w_cand = pcTarget;
      SRC_JALR:   w_cand = w_jalr_aligned;
      SRC_MRET:   w_cand = r_in_trap ? r_epc : w_pc_plus4;
      default:    w_cand = w_pc_plus4;
    endcase
  end

  always_comb begin
    w_mis_bits = 1'b0;
    if (ALIGN == 4) w_mis_bits = |w_cand[1:0];
    else            w_mis_bits = w_cand[0];
  end

  assign w_misaligned = !w_seq_like && w_mis_bits;
  assign w_trap       = trapReq || (!stall && w_misaligned);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_epc         <= '0;
      r_cause       <= CAUSE_NONE;
      r_trap_taken  <= 1'b0;
      r_in_trap     <= 1'b0;
      r_double_trap <= 1'b0;
    end else if (w_trap) begin
      r_pc         <= TRAP_VECTOR;
      r_cause      <= trapReq ? CAUSE_EXT : CAUSE_MISALIGN;
      r_trap_taken <= 1'b1;
      if (r_in_trap) begin
        r_double_trap <= 1'b1;
      end else begin
        r_epc     <= r_pc;
        r_in_trap <= 1'b1;
      end
    end else begin
      r_trap_taken <= 1'b0;
      if (!stall) begin
        r_pc <= w_cand;
        if (w_do_mret) r_in_trap <= 1'b0;
      end
    end
  end

  assign pc         = r_pc;
  assign pcPlus4    = w_pc_plus4;
  assign epc        = r_epc;
  assign trapCause  = r_cause;
  assign trapTaken  = r_trap_taken;
  assign inTrap     = r_in_trap;
  assign doubleTrap = r_double_trap;

endmodule

// File: doc/pc_gen_unit.md
PC_GEN_UNIT -- requirements
Module: pc_gen_unit

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, PC value loaded on any trap.
REQ-004 Parameter ALIGN, default 4, legal values 2 or 4; fetch alignment in bytes.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold PC and all state this cycle (except trap, REQ-015).
REQ-008 pcSrc  in  2  00 sequential, 01 branch/jal target, 10 jalr target, 11 mret.
REQ-009 pcTarget  in  XLEN  branch/jal target address.
REQ-010 jalrTarget  in  XLEN  jalr sum; bit 0 forced to 0 internally.
REQ-011 trapReq  in  1  external trap request (illegal instruction, ecall).
REQ-012 pc, pcPlus4  out  XLEN each  current PC register; pc + 4, combinational, modulo 2^XLEN.
REQ-013 epc, trapCause  out  XLEN, 2  saved exception PC; last cause 00 none, 01 misaligned fetch, 10 external.
REQ-014 trapTaken, inTrap, doubleTrap  out  1 each  one-cycle pulse after a trap redirect; trap handler active; sticky nested-trap flag.

Function
REQ-015 Next-PC priority, highest first: reset, trapReq, stall, misaligned candidate, pcSrc selection; trapReq overrides stall.
REQ-016 Candidate: pcSrc 00 -> pcPlus4; 01 -> pcTarget; 10 -> {jalrTarget[XLEN-1:1],0}; 11 -> epc if inTrap=1, else pcPlus4.
REQ-017 Candidate is misaligned when ALIGN=4 and bits[1:0]!=0, or ALIGN=2 and bit0!=0; pcSrc 00 never flags misaligned.
REQ-018 stall=1 with trapReq=0: pc, epc, trapCause, inTrap, doubleTrap unchanged; trapTaken=0 next cycle.
REQ-019 Trap (trapReq=1, or misaligned candidate with stall=0): pc<=TRAP_VECTOR next edge; trapCause<=10 for trapReq, else 01.
REQ-020 Trap with inTrap=0: epc<=current pc, inTrap<=1.
REQ-021 Trap with inTrap=1: epc unchanged, doubleTrap<=1, inTrap stays 1.
REQ-022 trapTaken is registered: high exactly one cycle after each trap edge, low otherwise; back-to-back traps give consecutive high cycles.
REQ-023 mret (pcSrc=11, inTrap=1, no trap, no stall): pc<=epc, inTrap<=0; epc, trapCause unchanged.
REQ-024 mret with inTrap=0 behaves as pcSrc 00; no state other than pc changes.
REQ-025 Simultaneous trapReq and mret: trap wins, mret ignored; epc handling per REQ-020/021.
REQ-026 PC increment wraps modulo 2^XLEN with no flag (all-ones-minus-3 + 4 -> 0).
REQ-027 Latency: one cycle from inputs to pc update; pc is glitch-free register output.

Reset
REQ-028 On reset=1 at a rising edge: pc=RESET_VECTOR, epc=0, trapCause=00, inTrap=0, doubleTrap=0, trapTaken=0.
REQ-029 Reset overrides stall, trapReq and pcSrc in the same cycle.
REQ-030 Reset mid-handler clears inTrap and doubleTrap; the first post-reset edge with reset=0 evaluates normally.
REQ-031 doubleTrap clears only on reset.

Verification
REQ-032 Reset then 3 cycles pcSrc=00: pc 0x0 -> 0x4 -> 0x8 -> 0xC; trapTaken stays 0.
REQ-033 pc=0x20, pcSrc=01, pcTarget=0x22, ALIGN=4: pc=0x100, epc=0x20, trapCause=01, trapTaken pulses one cycle, inTrap=1.
REQ-034 Same case with ALIGN=2: pc=0x22, no trap; jalrTarget=0x45 with pcSrc=10 -> pc=0x44.
REQ-035 pc=0x40, trapReq=1 and stall=1: pc=0x100, epc=0x40; then trapReq again at 0x104: epc stays 0x40, doubleTrap=1; then pcSrc=11 -> pc=0x40, inTrap=0.
REQ-036 stall=1 for 4 cycles at pc=0x10 with pcSrc=01, pcTarget=0x80: pc holds 0x10; stall drop -> pc=0x80.
REQ-037 pc=0xFFFF_FFFC, pcSrc=00: pc=0x0; reset asserted while inTrap=1 -> pc=RESET_VECTOR, inTrap=0, doubleTrap=0.
